// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port controller.
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_NREGS  = 32;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = 5'd0;

  typedef enum logic {ST_INIT, ST_RUN} rfctl_state_t;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wr_ctrl_if.sv
// Requester handshake plus the registered regfile write port (we3/wa3/wd3).
interface regfile_wr_ctrl_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   we3;
  logic [ADDR_W-1:0]      wa3;
  logic [DATA_W-1:0]      wd3;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, we3, wa3, wd3
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, we3, wa3, wd3
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i (mod N) wins.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PtrW'((32'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the 32x32 regfile: optional post-reset zero sweep
// (enabled by RFCTL_INIT_EN), then round-robin sharing of we3/wa3/wd3 among NREQ sources.
module regfile_wr_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold_i,
  regfile_wr_ctrl_if.slave   bus,
  output logic               init_done_o
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                 run;
  logic [NREQ-1:0]      gnt;
  logic [PtrW-1:0]      gnt_idx;
  logic                 xfer;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;

  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 we3_q, we3_d;
  logic [ADDR_W-1:0]    wa3_q, wa3_d;
  logic [DATA_W-1:0]    wd3_q, wd3_d;

  rr_arbiter #(
    .N    (NREQ),
    .PtrW (PtrW)
  ) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  assign bus.req_ready = (run && !hold_i && !rst) ? gnt : '0;
  assign xfer          = |bus.req_ready;

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = PtrW'(i);
    end
  end

  assign sel_addr = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data = bus.req_data[gnt_idx*DATA_W +: DATA_W];

`ifdef RFCTL_INIT_EN
  rfctl_state_t      state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;

  assign run         = (state_q == ST_RUN);
  assign init_done_o = init_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= ADDR_W'(1);
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end
`else
  assign run         = 1'b1;
  assign init_done_o = 1'b1;
`endif

  always_comb begin
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    rr_ptr_d = rr_ptr_q;
`ifdef RFCTL_INIT_EN
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_INIT: begin
        if (!hold_i) begin
          we3_d      = 1'b1;
          wa3_d      = init_cnt_q;
          wd3_d      = '0;
          init_cnt_d = init_cnt_q + ADDR_W'(1);
          // Register 0 is skipped, so the all-ones address is the final sweep write.
          if (init_cnt_q == '1) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end
        end
      end
      ST_RUN: ;
      default: state_d = ST_RUN;
    endcase
`endif
    if (xfer) begin
      rr_ptr_d = PtrW'(rr_next(32'(gnt_idx), NREQ));
      // Writes to register 0 are consumed but never reach the regfile.
      if (sel_addr != ADDR_W'(RF_ZERO_ADDR)) begin
        we3_d = 1'b1;
        wa3_d = sel_addr;
        wd3_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign bus.we3 = we3_q;
  assign bus.wa3 = wa3_q;
  assign bus.wd3 = wd3_q;

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Randomized bench for regfile_wr_ctrl against a cycle-level reference model; honours RFCTL_INIT_EN.
module tb_regfile_wr_ctrl;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
`ifdef RFCTL_INIT_EN
  localparam int unsigned SWEEP_N = 31;
`else
  localparam int unsigned SWEEP_N = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic init_done;

  regfile_wr_ctrl_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wr_ctrl #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (hold),
    .bus         (bus),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_init_left, m_next_init, m_ptr;
  logic        m_we3, m_done;
  logic [31:0] m_wa3, m_wd3;
  int          wait_n [NREQ];
  logic [NREQ-1:0] last_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return bus.req_addr[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input int i);
    return bus.req_data[i*DATA_W +: DATA_W];
  endfunction

  task automatic model_reset();
    m_init_left = SWEEP_N;
    m_next_init = 1;
    m_ptr       = 0;
    m_we3       = 1'b0;
    m_wa3       = '0;
    m_wd3       = '0;
    m_done      = (SWEEP_N == 0);
    last_rdy    = '0;
    for (int i = 0; i < NREQ; i++) wait_n[i] = 0;
  endtask

  // Which requester the rules say must be granted right now (-1 for none).
  function automatic int model_grant();
    if (m_init_left > 0 || hold) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs driven: compare, then advance model one clock.
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [ADDR_W-1:0] ga;
    logic [DATA_W-1:0] gd;
    #1;
    g       = model_grant();
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("we3", 64'(bus.we3), 64'(m_we3));
    chk("init_done", 64'(init_done), 64'(m_done));
    if (m_we3) begin
      chk("wa3", 64'(bus.wa3), 64'(m_wa3));
      chk("wd3", 64'(bus.wd3), 64'(m_wd3));
    end
    if (g >= 0) chk("fair_wait", 64'(wait_n[g] <= NREQ - 1), 64'(1));
    for (int i = 0; i < NREQ; i++) begin
      if (i == g || !bus.req_valid[i]) wait_n[i] = 0;
      else if (g >= 0) wait_n[i]++;
    end
    last_rdy = exp_rdy;
    ga = (g >= 0) ? addr_of(g) : '0;
    gd = (g >= 0) ? data_of(g) : '0;
    @(posedge clk);
    if (m_init_left > 0) begin
      m_we3 = !hold;
      if (!hold) begin
        m_wa3 = 32'(m_next_init);
        m_wd3 = '0;
        m_next_init++;
        m_init_left--;
        if (m_init_left == 0) m_done = 1'b1;
      end
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      m_we3 = (ga != 0);
      if (ga != 0) begin
        m_wa3 = 32'(ga);
        m_wd3 = 32'(gd);
      end
    end else begin
      m_we3 = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    bus.req_valid[i] = v;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    chk("rst_we3", 64'(bus.we3), 64'(0));
    chk("rst_wa3", 64'(bus.wa3), 64'(0));
    chk("rst_wd3", 64'(bus.wd3), 64'(0));
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_init_done", 64'(init_done), 64'(SWEEP_N == 0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_done();
    for (int i = 0; i < 100 && !m_done; i++) step();
  endtask

  initial begin
    int cyc;
    int held;
    bit did_mid_rst;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    @(negedge clk);
    reset_dut();

`ifdef RFCTL_INIT_EN
    // Sweep with a 4-cycle hold after wa3=10, random requests ignored throughout.
    cyc  = 0;
    held = 0;
    for (int i = 0; i < 100 && !m_done; i++) begin
      bus.req_valid = NREQ'($urandom);
      hold = (m_next_init == 11 && held < 4);
      if (hold) held++;
      step();
      cyc++;
      if (cyc == 1) chk("sweep_first_wa3", 64'(bus.wa3), 64'(1));
    end
    hold = 1'b0;
    chk("sweep_len", 64'(cyc), 64'(35));
    chk("sweep_last_wa3", 64'(bus.wa3), 64'(31));
    bus.req_valid = '0;
`endif

    // Single requester 0, addr 5
    set_req(0, 1'b1, 5'd5, 32'h0000_0005);
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1 chk("t2_ready", 64'(bus.req_ready), 64'(2'b01));
    step();
    chk("t2_we3", 64'(bus.we3), 64'(1));
    chk("t2_wa3", 64'(bus.wa3), 64'(5));
    chk("t2_wd3", 64'(bus.wd3), 64'(32'h5));
    bus.req_valid = '0;
    step();
    chk("t2_we3_drop", 64'(bus.we3), 64'(0));

    // Both valid from a fresh pointer: strict alternation
    reset_dut();
    run_until_done();
    set_req(0, 1'b1, 5'd3, 32'hAAAA_AAAA);
    set_req(1, 1'b1, 5'd4, 32'hBBBB_BBBB);
    for (int j = 0; j < 4; j++) begin
      #1 chk("t3_ready", 64'(bus.req_ready), (j % 2) ? 64'(2'b10) : 64'(2'b01));
      step();
      chk("t3_wa3", 64'(bus.wa3), (j % 2) ? 64'(4) : 64'(3));
      chk("t3_wd3", 64'(bus.wd3), (j % 2) ? 64'hBBBB_BBBB : 64'hAAAA_AAAA);
    end

    // hold in RUN: no grants, we3 low, wa3 keeps last value
    hold = 1'b1;
    for (int j = 0; j < 2; j++) step();
    chk("hold_we3", 64'(bus.we3), 64'(0));
    chk("hold_wa3", 64'(bus.wa3), 64'(4));
    hold = 1'b0;

    // Address 0 request is consumed without a write
    set_req(0, 1'b0, 5'd3, 32'h0);
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1 chk("t4_ready", 64'(bus.req_ready), 64'(2'b10));
    step();
    chk("t4_we3", 64'(bus.we3), 64'(0));
    bus.req_valid = '0;
    step();

    // Randomized traffic with stable-while-waiting requesters and one mid-run reset
    did_mid_rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && !last_rdy[i]) begin
          if ($urandom_range(7) == 0) bus.req_valid[i] = 1'b0;
        end else begin
          set_req(i, ($urandom_range(3) != 0), ADDR_W'($urandom_range(31)), $urandom);
        end
      end
      hold = ($urandom_range(9) == 0);
      if (!did_mid_rst && n > 1500 && m_we3 && m_done) begin
        did_mid_rst = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_we3", 64'(bus.we3), 64'(0));
        chk("midrst_ready", 64'(bus.req_ready), 64'(0));
        chk("midrst_init_done", 64'(init_done), 64'(SWEEP_N == 0));
        model_reset();
        @(negedge clk);
        rst  = 1'b0;
        hold = 1'b0;
        step();
`ifdef RFCTL_INIT_EN
        chk("midrst_restart_wa3", 64'(bus.wa3), 64'(1));
        chk("midrst_restart_we3", 64'(bus.we3), 64'(1));
`endif
      end else begin
        step();
      end
    end
    chk("mid_reset_reached", 64'(did_mid_rst), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
